psum_mem_arb: RTL and testbench
===============================

# psum_mem_arb

Arbiter and sequencer for the single dual-port partial-sum buffer behind the psum accumulator controller. It shares the buffer between three users:
- the accumulator's read-modify-write stream (port A, highest priority, never stalled);
- the output drain reader that streams finished outputs to the DMA (port B, opportunistic);
- an internal clear engine that zero-fills the buffer before a new layer.

It sits between the psum accumulator controller, the drain reader and the memory controller, and routes read data back to the requester that issued each read.

## Interface
Parameters:
- DATA_WIDTH, 32, memory word width
- ADDR_WIDTH, 32, memory address width
- MEM_DELAY, 1, read latency of the memory in cycles (mem_radd/mem_rden to mem_ovld), 1..4
- REG_WIDTH, 32, width of the clear length and debug counters

Ports (reset is asynchronous, active-low):
- clk  in  1  single clock
- rst_n  in  1  asynchronous active-low reset
- a_radd  in  ADDR_WIDTH  accumulator read address
- a_rden  in  1  accumulator read strobe
- a_wadd  in  ADDR_WIDTH  accumulator write address
- a_wren  in  1  accumulator write strobe
- a_idat  in  DATA_WIDTH  accumulator write data
- a_odat  out  DATA_WIDTH  read data returned to A
- a_ovld  out  1  read data valid for A
- b_req  in  1  drain read request
- b_radd  in  ADDR_WIDTH  drain read address
- b_gnt  out  1  drain request accepted this cycle
- b_odat  out  DATA_WIDTH  read data returned to B
- b_ovld  out  1  read data valid for B
- clr_start  in  1  one-cycle pulse that starts a clear
- clr_len  in  REG_WIDTH  number of words to clear, starting at address 0
- clr_busy  out  1  clear in progress
- clr_done  out  1  one-cycle pulse after the last clear write
- err_clr_col  out  1  sticky flag: A wrote during a clear
- mem_radd  out  ADDR_WIDTH  memory read address
- mem_rden  out  1  memory read strobe
- mem_odat  in  DATA_WIDTH  memory read data
- mem_ovld  in  1  memory read data valid
- mem_wadd  out  ADDR_WIDTH  memory write address
- mem_wren  out  1  memory write strobe
- mem_idat  out  DATA_WIDTH  memory write data
- dbg_b_stall_cnt  out  REG_WIDTH  cycles with b_req high and b_gnt low
- dbg_clr_col_cnt  out  REG_WIDTH  count of clear cycles lost to A writes

## Operation
FSM has two states, IDLE and CLEAR; reset state is IDLE.
- IDLE -> CLEAR on clr_start when clr_len != 0. The clear address counter loads 0 and clr_busy rises the next cycle.
- clr_start with clr_len == 0: no writes; clr_done pulses the next cycle; the FSM stays in IDLE.
- clr_start while in CLEAR is ignored.
- CLEAR -> IDLE after the write at address clr_len-1 is issued. clr_done pulses in the same cycle as the FSM returns to IDLE.

Read port (combinational mux):
- a_rden has absolute priority.
- b_gnt = b_req & ~a_rden & (state == IDLE).
- mem_rden = a_rden | b_gnt. mem_radd selects a_radd or b_radd accordingly.

Write port:
- a_wren has absolute priority.
- In CLEAR with ~a_wren, the block writes all-zero data at the clear address, then increments the address.
- In CLEAR with a_wren: A's write is passed to memory, the clear address holds, err_clr_col sets and dbg_clr_col_cnt increments.
- err_clr_col clears on reset or on an accepted clr_start.

Return routing:
- An owner tag (A or B) is pushed for every issued read into a MEM_DELAY-deep tag pipe.
- a_ovld = mem_ovld & tag==A; b_ovld = mem_ovld & tag==B.
- a_odat and b_odat both carry mem_odat unregistered.
- A mem_ovld with no read in flight (tag pipe empty) is dropped.

Arithmetic: the clear counter is ADDR_WIDTH wide, compared against clr_len-1. The debug counters saturate at all-ones.

## Timing
- Read issue: same cycle as the request (combinational grant). Data returns exactly MEM_DELAY cycles later.
- Clear: clr_len writes take at least clr_len cycles, plus one cycle per colliding A write. clr_busy is registered.
- Async reset sets all registered outputs to 0: clr_busy, clr_done, err_clr_col, tag pipe valid bits, clear counter, debug counters. The FSM returns to IDLE.
- Reset mid-clear aborts the clear with no clr_done. Reads already in flight at reset are not routed.
- Simultaneous a_rden and b_req: A is issued, b_gnt is 0, and B must hold b_req/b_radd.

## Configuration
- PSUM_ARB_STAT_EN defined: dbg_b_stall_cnt and dbg_clr_col_cnt are implemented as saturating counters.
- PSUM_ARB_STAT_EN undefined: both counters are removed and the outputs are tied to 0. err_clr_col is still present.

## Structure
- Package psum_arb_pkg holds the state encoding (ST_IDLE, ST_CLEAR) and the owner tag constants (TAG_A=1'b0, TAG_B=1'b1).
- Sub-module psum_arb_tag_pipe: a MEM_DELAY-stage shift register of {valid, tag}, with async active-low reset.

## Test plan
- MEM_DELAY=2; a_rden at addr 5 and b_req at addr 9 in the same cycle -> mem_radd=5, b_gnt=0. Next cycle B is granted. a_ovld 2 cycles after A's issue, b_ovld 2 cycles after B's issue, with no cross-routing.
- clr_start, clr_len=4, A idle -> zero writes at addresses 0,1,2,3 on consecutive cycles. clr_done pulses with the addr-3 write. clr_busy is high for 4 cycles.
- Clear of length 4 with a_wren to addr 7 on the second clear cycle -> mem_wadd sequence 0,7,1,2,3. err_clr_col=1; dbg_clr_col_cnt=1 with PSUM_ARB_STAT_EN.
- b_req held high during a 3-word clear -> b_gnt=0 for 3 cycles, then 1. dbg_b_stall_cnt=3 (0 without the macro).
- clr_len=0 -> no mem_wren, clr_done one cycle later. Then clr_start again while busy (len=8), with a second clr_start 2 cycles in -> exactly 8 writes.
- rst_n asserted mid-clear with a read in flight -> all outputs 0 immediately. No a_ovld/b_ovld for that read, and no clr_done.

Source files
------------

// File: rtl/psum_arb_pkg.sv
// Shared types for the psum buffer arbiter: FSM state encoding and read-owner tags.
package psum_arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } arb_state_e;

    localparam logic TAG_A = 1'b0;
    localparam logic TAG_B = 1'b1;

    typedef struct packed {
        logic vld;
        logic tag;
    } rd_tag_t;

endpackage

// File: rtl/psum_mem_arb_if.sv
// Bundle of the accumulator, drain, clear and memory-side signals of psum_mem_arb.
// slave is the arbiter's view; master is the view of the surrounding clients and memory.
interface psum_mem_arb_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int REG_WIDTH  = 32
);
    logic [ADDR_WIDTH-1:0] a_radd;
    logic                  a_rden;
    logic [ADDR_WIDTH-1:0] a_wadd;
    logic                  a_wren;
    logic [DATA_WIDTH-1:0] a_idat;
    logic [DATA_WIDTH-1:0] a_odat;
    logic                  a_ovld;
    logic                  b_req;
    logic [ADDR_WIDTH-1:0] b_radd;
    logic                  b_gnt;
    logic [DATA_WIDTH-1:0] b_odat;
    logic                  b_ovld;
    logic                  clr_start;
    logic [REG_WIDTH-1:0]  clr_len;
    logic                  clr_busy;
    logic                  clr_done;
    logic                  err_clr_col;
    logic [ADDR_WIDTH-1:0] mem_radd;
    logic                  mem_rden;
    logic [DATA_WIDTH-1:0] mem_odat;
    logic                  mem_ovld;
    logic [ADDR_WIDTH-1:0] mem_wadd;
    logic                  mem_wren;
    logic [DATA_WIDTH-1:0] mem_idat;
    logic [REG_WIDTH-1:0]  dbg_b_stall_cnt;
    logic [REG_WIDTH-1:0]  dbg_clr_col_cnt;

    modport slave (
        input  a_radd, a_rden, a_wadd, a_wren, a_idat, b_req, b_radd,
               clr_start, clr_len, mem_odat, mem_ovld,
        output a_odat, a_ovld, b_gnt, b_odat, b_ovld, clr_busy, clr_done,
               err_clr_col, mem_radd, mem_rden, mem_wadd, mem_wren, mem_idat,
               dbg_b_stall_cnt, dbg_clr_col_cnt
    );

    modport master (
        output a_radd, a_rden, a_wadd, a_wren, a_idat, b_req, b_radd,
               clr_start, clr_len, mem_odat, mem_ovld,
        input  a_odat, a_ovld, b_gnt, b_odat, b_ovld, clr_busy, clr_done,
               err_clr_col, mem_radd, mem_rden, mem_wadd, mem_wren, mem_idat,
               dbg_b_stall_cnt, dbg_clr_col_cnt
    );

endinterface

// File: rtl/psum_arb_tag_pipe.sv
// Owner-tag delay line: {valid, tag} of each issued read emerges STAGES cycles later,
// aligned with the memory's read data.
module psum_arb_tag_pipe
    import psum_arb_pkg::*;
#(
    parameter int STAGES = 1
) (
    input  logic    clk,
    input  logic    rst_n,
    input  rd_tag_t push,
    output rd_tag_t head
);

    logic [STAGES:1] vld_pipe;
    logic [STAGES:1] tag_pipe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            tag_pipe <= '0;
        end else begin
            vld_pipe[1] <= push.vld;
            tag_pipe[1] <= push.tag;
            for (int i = 2; i <= STAGES; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    assign head.vld = vld_pipe[STAGES];
    assign head.tag = tag_pipe[STAGES];

endmodule

// File: rtl/psum_mem_arb.sv
// Shares the dual-port psum buffer between the accumulator (A), the drain reader (B) and
// the zero-fill clear engine. Optional debug counters under PSUM_ARB_STAT_EN.
module psum_mem_arb
    import psum_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_DELAY  = 1,
    parameter int REG_WIDTH  = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    psum_mem_arb_if.slave  bus
);

    arb_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_addr_q;
    logic [REG_WIDTH-1:0]  clr_len_q;
    logic                  clr_busy_q;
    logic                  zero_done_q;
    logic                  err_q;
    logic                  start_ok;
    logic                  clr_last;
    logic                  a_col;
    logic                  b_gnt;
    rd_tag_t               tag_push, tag_head;

    assign start_ok = (state_q == ST_IDLE) & bus.clr_start;
    assign a_col    = (state_q == ST_CLEAR) & bus.a_wren;

    always_comb begin
        state_d  = state_q;
        clr_last = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.clr_start && (bus.clr_len != '0)) state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                clr_last = ~bus.a_wren && (clr_addr_q == ADDR_WIDTH'(clr_len_q - 1'b1));
                if (clr_last) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Length is latched at start so a mid-clear change of clr_len cannot shorten the fill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            clr_addr_q  <= '0;
            clr_len_q   <= '0;
            clr_busy_q  <= 1'b0;
            zero_done_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_busy_q  <= (state_d == ST_CLEAR);
            zero_done_q <= start_ok & (bus.clr_len == '0);
            if (start_ok) begin
                clr_addr_q <= '0;
                clr_len_q  <= bus.clr_len;
            end else if ((state_q == ST_CLEAR) && !bus.a_wren) begin
                clr_addr_q <= clr_addr_q + 1'b1;
            end
            if (start_ok)   err_q <= 1'b0;
            else if (a_col) err_q <= 1'b1;
        end
    end

    // Read port: A always wins, B only gets idle, non-clearing cycles.
    assign b_gnt        = bus.b_req & ~bus.a_rden & (state_q == ST_IDLE);
    assign bus.b_gnt    = b_gnt;
    assign bus.mem_rden = bus.a_rden | b_gnt;
    assign bus.mem_radd = bus.a_rden ? bus.a_radd : bus.b_radd;

    assign bus.mem_wren = bus.a_wren | (state_q == ST_CLEAR);
    assign bus.mem_wadd = bus.a_wren ? bus.a_wadd : clr_addr_q;
    assign bus.mem_idat = bus.a_wren ? bus.a_idat : '0;

    assign bus.clr_busy    = clr_busy_q;
    assign bus.clr_done    = zero_done_q | clr_last;
    assign bus.err_clr_col = err_q;

    assign tag_push.vld = bus.mem_rden;
    assign tag_push.tag = bus.a_rden ? TAG_A : TAG_B;

    psum_arb_tag_pipe #(.STAGES(MEM_DELAY)) u_tag_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (tag_push),
        .head  (tag_head)
    );

    // Returns with an empty pipe head are stray and dropped.
    assign bus.a_ovld = bus.mem_ovld & tag_head.vld & (tag_head.tag == TAG_A);
    assign bus.b_ovld = bus.mem_ovld & tag_head.vld & (tag_head.tag == TAG_B);
    assign bus.a_odat = bus.mem_odat;
    assign bus.b_odat = bus.mem_odat;

`ifdef PSUM_ARB_STAT_EN
    logic [REG_WIDTH-1:0] stall_cnt_q, col_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            col_cnt_q   <= '0;
        end else begin
            if (bus.b_req && !b_gnt && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
            if (a_col && (col_cnt_q != '1))                 col_cnt_q   <= col_cnt_q + 1'b1;
        end
    end

    assign bus.dbg_b_stall_cnt = stall_cnt_q;
    assign bus.dbg_clr_col_cnt = col_cnt_q;
`else
    assign bus.dbg_b_stall_cnt = '0;
    assign bus.dbg_clr_col_cnt = '0;
`endif

endmodule

// File: tb/tb_psum_mem_arb.sv
// Bench for psum_mem_arb: reset, hand sequences, a vector table and a randomized run
// against a queue-based reference model with a fixed-latency memory model.
module tb_psum_mem_arb;
    localparam int DW = 32, AW = 32, RW = 32, MD = 2;
`ifdef PSUM_ARB_STAT_EN
    localparam bit STAT = 1'b1;
`else
    localparam bit STAT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    psum_mem_arb_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REG_WIDTH(RW)) bus ();

    psum_mem_arb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_DELAY(MD), .REG_WIDTH(RW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [DW-1:0] memf(logic [AW-1:0] a);
        return {a[15:0] ^ 16'hA5C3, a[15:0]};
    endfunction

    // Memory: fixed MD-cycle read latency, not affected by the arbiter reset.
    logic [MD-1:0] rd_v = '0;
    logic [DW-1:0] rd_d [MD];
    logic          spur = 1'b0;
    always @(posedge clk) begin
        rd_v[0] <= bus.mem_rden;
        rd_d[0] <= memf(bus.mem_radd);
        for (int i = 1; i < MD; i++) begin
            rd_v[i] <= rd_v[i-1];
            rd_d[i] <= rd_d[i-1];
        end
    end
    assign bus.mem_ovld = rd_v[MD-1] | spur;
    assign bus.mem_odat = spur ? 32'hDEAD_BEEF : rd_d[MD-1];

    int checks = 0, errors = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model state
    typedef struct { int due; bit own_b; logic [AW-1:0] addr; } rd_t;
    rd_t           rq[$];
    int            cyc = 0;
    bit            m_busy, m_err, m_zdone;
    logic [AW-1:0] m_caddr;
    int            m_left;
    longint        m_stall, m_col;
    bit            e_gnt, e_rden, e_own_b;
    logic [AW-1:0] e_radd;

    task automatic model_reset();
        m_busy = 0; m_err = 0; m_zdone = 0; m_caddr = '0; m_left = 0;
        m_stall = 0; m_col = 0; rq.delete();
    endtask

    task automatic clear_inputs();
        bus.a_radd = '0; bus.a_rden = 0; bus.a_wadd = '0; bus.a_wren = 0; bus.a_idat = '0;
        bus.b_req = 0; bus.b_radd = '0; bus.clr_start = 0; bus.clr_len = '0; spur = 0;
    endtask

    task automatic sample();
        bit gnt, wr, done, av, bv;
        logic [AW-1:0] ra, wa;
        logic [DW-1:0] wd, rdat;
        @(negedge clk);
        gnt  = bus.b_req && !bus.a_rden && !m_busy;
        ra   = bus.a_rden ? bus.a_radd : bus.b_radd;
        wr   = bus.a_wren || m_busy;
        wa   = bus.a_wren ? bus.a_wadd : m_caddr;
        wd   = bus.a_wren ? bus.a_idat : '0;
        done = m_zdone || (m_busy && !bus.a_wren && m_left == 1);
        av = 0; bv = 0; rdat = '0;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            av = !rq[0].own_b; bv = rq[0].own_b; rdat = memf(rq[0].addr);
        end
        chk("b_gnt", bus.b_gnt, gnt);
        chk("mem_rden", bus.mem_rden, bus.a_rden || gnt);
        if (bus.a_rden || gnt) chk("mem_radd", bus.mem_radd, ra);
        chk("mem_wren", bus.mem_wren, wr);
        if (wr) begin
            chk("mem_wadd", bus.mem_wadd, wa);
            chk("mem_idat", bus.mem_idat, wd);
        end
        chk("clr_busy", bus.clr_busy, m_busy);
        chk("clr_done", bus.clr_done, done);
        chk("err_clr_col", bus.err_clr_col, m_err);
        chk("a_ovld", bus.a_ovld, av);
        chk("b_ovld", bus.b_ovld, bv);
        if (av) chk("a_odat", bus.a_odat, rdat);
        if (bv) chk("b_odat", bus.b_odat, rdat);
        chk("dbg_b_stall_cnt", bus.dbg_b_stall_cnt, STAT ? m_stall : 0);
        chk("dbg_clr_col_cnt", bus.dbg_clr_col_cnt, STAT ? m_col : 0);
        e_gnt = gnt; e_rden = bus.a_rden || gnt; e_own_b = !bus.a_rden; e_radd = ra;
    endtask

    task automatic advance();
        @(posedge clk); #1;
        if (rq.size() > 0 && rq[0].due == cyc) void'(rq.pop_front());
        if (e_rden) rq.push_back('{cyc + MD, e_own_b, e_radd});
        if (bus.b_req && !e_gnt) m_stall++;
        m_zdone = !m_busy && bus.clr_start && bus.clr_len == 0;
        if (!m_busy) begin
            if (bus.clr_start) begin
                m_err = 0;
                if (bus.clr_len != 0) begin m_busy = 1; m_caddr = '0; m_left = int'(bus.clr_len); end
            end
        end else if (bus.a_wren) begin
            m_err = 1; m_col++;
        end else begin
            m_caddr++; m_left--;
            if (m_left == 0) m_busy = 0;
        end
        cyc++;
    endtask

    task automatic step();
        sample();
        advance();
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        model_reset();
    endtask

    typedef struct {
        bit a_rden; logic [7:0] a_radd; bit b_req; logic [7:0] b_radd;
        bit a_wren; logic [7:0] a_wadd; logic [31:0] a_idat;
        bit e_gnt; bit e_rden; logic [7:0] e_radd; bit e_wren; logic [7:0] e_wadd; logic [31:0] e_idat;
    } vec_t;
    vec_t tv [8];

    logic [AW-1:0] col_wa [5];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nw;
        clear_inputs();
        rst_n = 1;
        #1 rst_n = 0;
        #1;
        chk("rst clr_busy", bus.clr_busy, 0);
        chk("rst clr_done", bus.clr_done, 0);
        chk("rst err_clr_col", bus.err_clr_col, 0);
        chk("rst a_ovld", bus.a_ovld, 0);
        chk("rst b_ovld", bus.b_ovld, 0);
        chk("rst mem_wren", bus.mem_wren, 0);
        chk("rst dbg_b_stall_cnt", bus.dbg_b_stall_cnt, 0);
        chk("rst dbg_clr_col_cnt", bus.dbg_clr_col_cnt, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        model_reset();
        step();

        // A and B collide: A first, B next cycle, returns routed MD cycles after each issue
        bus.a_rden = 1; bus.a_radd = 5; bus.b_req = 1; bus.b_radd = 9;
        sample();
        chk("ab mem_radd", bus.mem_radd, 5);
        chk("ab b_gnt", bus.b_gnt, 0);
        advance();
        bus.a_rden = 0;
        sample();
        chk("ab b_gnt next", bus.b_gnt, 1);
        chk("ab mem_radd next", bus.mem_radd, 9);
        advance();
        bus.b_req = 0;
        sample();
        chk("ab a_ovld", bus.a_ovld, 1);
        chk("ab a_odat", bus.a_odat, memf(5));
        chk("ab b_ovld early", bus.b_ovld, 0);
        advance();
        sample();
        chk("ab b_ovld", bus.b_ovld, 1);
        chk("ab b_odat", bus.b_odat, memf(9));
        chk("ab a_ovld late", bus.a_ovld, 0);
        advance();
        step();

        // Plain clear of 4 words
        bus.clr_start = 1; bus.clr_len = 4;
        sample();
        chk("clr4 busy pre", bus.clr_busy, 0);
        advance();
        bus.clr_start = 0;
        for (int k = 0; k < 4; k++) begin
            sample();
            chk("clr4 wren", bus.mem_wren, 1);
            chk("clr4 wadd", bus.mem_wadd, k);
            chk("clr4 idat", bus.mem_idat, 0);
            chk("clr4 busy", bus.clr_busy, 1);
            chk("clr4 done", bus.clr_done, k == 3);
            advance();
        end
        sample();
        chk("clr4 busy post", bus.clr_busy, 0);
        chk("clr4 wren post", bus.mem_wren, 0);
        advance();

        // Clear with one colliding A write
        col_wa = '{32'd0, 32'd7, 32'd1, 32'd2, 32'd3};
        bus.clr_start = 1; bus.clr_len = 4;
        step();
        bus.clr_start = 0; bus.a_wadd = 7; bus.a_idat = 32'h1234;
        for (int k = 0; k < 5; k++) begin
            bus.a_wren = (k == 1);
            sample();
            chk("col wadd", bus.mem_wadd, col_wa[k]);
            chk("col idat", bus.mem_idat, (k == 1) ? 32'h1234 : 32'h0);
            advance();
        end
        bus.a_wren = 0;
        sample();
        chk("col err", bus.err_clr_col, 1);
        chk("col cnt", bus.dbg_clr_col_cnt, STAT ? 1 : 0);
        advance();

        // B stalled through a 3-word clear
        do_reset();
        bus.clr_start = 1; bus.clr_len = 3;
        step();
        bus.clr_start = 0; bus.b_req = 1; bus.b_radd = 32'h44;
        for (int k = 0; k < 3; k++) begin
            sample();
            chk("stall b_gnt", bus.b_gnt, 0);
            advance();
        end
        sample();
        chk("stall b_gnt after", bus.b_gnt, 1);
        advance();
        bus.b_req = 0;
        sample();
        chk("stall cnt", bus.dbg_b_stall_cnt, STAT ? 3 : 0);
        advance();
        repeat (3) step();

        // Zero-length clear, then an 8-word clear with an ignored restart
        bus.clr_start = 1; bus.clr_len = 0;
        sample();
        chk("len0 wren", bus.mem_wren, 0);
        chk("len0 done early", bus.clr_done, 0);
        advance();
        bus.clr_start = 0;
        sample();
        chk("len0 done", bus.clr_done, 1);
        chk("len0 busy", bus.clr_busy, 0);
        chk("len0 wren next", bus.mem_wren, 0);
        advance();
        sample();
        chk("len0 done once", bus.clr_done, 0);
        advance();
        bus.clr_start = 1; bus.clr_len = 8;
        step();
        nw = 0;
        for (int k = 0; k < 12; k++) begin
            bus.clr_start = (k == 2);
            if (k == 2) bus.clr_len = 3;
            sample();
            nw += int'(bus.mem_wren);
            advance();
        end
        bus.clr_start = 0;
        chk("clr8 writes", nw, 8);

        // Reset mid-clear with an A read in flight
        bus.clr_start = 1; bus.clr_len = 8;
        step();
        bus.clr_start = 0;
        repeat (2) step();
        bus.a_rden = 1; bus.a_radd = 32'h77;
        step();
        clear_inputs();
        rst_n = 0;
        #1;
        chk("mid rst clr_busy", bus.clr_busy, 0);
        chk("mid rst clr_done", bus.clr_done, 0);
        chk("mid rst mem_wren", bus.mem_wren, 0);
        chk("mid rst mem_rden", bus.mem_rden, 0);
        chk("mid rst b_gnt", bus.b_gnt, 0);
        chk("mid rst a_ovld", bus.a_ovld, 0);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1;
        sample();
        chk("mid rst no a_ovld", bus.a_ovld, 0);
        chk("mid rst no done", bus.clr_done, 0);
        advance();
        repeat (3) step();

        // Idle-state vector table
        tv[0] = '{0, 8'h00, 0, 8'h00, 0, 8'h00, 32'h0,         0, 0, 8'h00, 0, 8'h00, 32'h0};
        tv[1] = '{1, 8'h10, 0, 8'h00, 0, 8'h00, 32'h0,         0, 1, 8'h10, 0, 8'h00, 32'h0};
        tv[2] = '{0, 8'h00, 1, 8'h22, 0, 8'h00, 32'h0,         1, 1, 8'h22, 0, 8'h00, 32'h0};
        tv[3] = '{1, 8'h31, 1, 8'h32, 0, 8'h00, 32'h0,         0, 1, 8'h31, 0, 8'h00, 32'h0};
        tv[4] = '{0, 8'h00, 0, 8'h00, 1, 8'h40, 32'hCAFE0001, 0, 0, 8'h00, 1, 8'h40, 32'hCAFE0001};
        tv[5] = '{1, 8'h51, 1, 8'h53, 1, 8'h52, 32'h12345678, 0, 1, 8'h51, 1, 8'h52, 32'h12345678};
        tv[6] = '{0, 8'h00, 1, 8'h61, 1, 8'h62, 32'h0,         1, 1, 8'h61, 1, 8'h62, 32'h0};
        tv[7] = '{1, 8'hFF, 0, 8'h00, 0, 8'h00, 32'h0,         0, 1, 8'hFF, 0, 8'h00, 32'h0};
        for (int i = 0; i < 8; i++) begin
            bus.a_rden = tv[i].a_rden; bus.a_radd = AW'(tv[i].a_radd);
            bus.b_req  = tv[i].b_req;  bus.b_radd = AW'(tv[i].b_radd);
            bus.a_wren = tv[i].a_wren; bus.a_wadd = AW'(tv[i].a_wadd); bus.a_idat = tv[i].a_idat;
            sample();
            chk("tv b_gnt", bus.b_gnt, tv[i].e_gnt);
            chk("tv mem_rden", bus.mem_rden, tv[i].e_rden);
            if (tv[i].e_rden) chk("tv mem_radd", bus.mem_radd, AW'(tv[i].e_radd));
            chk("tv mem_wren", bus.mem_wren, tv[i].e_wren);
            if (tv[i].e_wren) begin
                chk("tv mem_wadd", bus.mem_wadd, AW'(tv[i].e_wadd));
                chk("tv mem_idat", bus.mem_idat, tv[i].e_idat);
            end
            advance();
        end
        clear_inputs();
        repeat (3) step();

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            bus.a_rden = ($urandom_range(0, 9) < 3);
            bus.a_radd = AW'($urandom_range(0, 255));
            if (!(bus.b_req && !e_gnt)) begin
                bus.b_req  = ($urandom_range(0, 9) < 5);
                bus.b_radd = AW'($urandom_range(0, 255));
            end
            bus.a_wren    = ($urandom_range(0, 9) < 2);
            bus.a_wadd    = AW'($urandom_range(0, 255));
            bus.a_idat    = $urandom();
            bus.clr_start = ($urandom_range(0, 99) < 4);
            bus.clr_len   = RW'($urandom_range(0, 6));
            spur = !(rq.size() > 0 && rq[0].due == cyc) && ($urandom_range(0, 9) == 0);
            step();
        end
        clear_inputs();
        repeat (MD + 8) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
